// File: rtl/mult_div_unit.sv
// mult_div_unit: execute-stage multiply/divide unit with HI/LO registers.
// Handles mult/multu/div/divu/mthi/mtlo. A busy counter models the
// multi-cycle latency, and Start/Busy drive the decode-stage stall logic.
// Optional feature: define MDU_MADD_EN to accept madd/maddu/msub/msubu.
// These accumulate into {HI,LO} and have MULT_CYCLES latency.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'b0111;
    localparam logic [3:0] OP_MADDU = 4'b1000;
    localparam logic [3:0] OP_MSUB  = 4'b1001;
    localparam logic [3:0] OP_MSUBU = 4'b1010;

    // Completion action for the held result: load, add to or subtract from {HI,LO}.
    localparam logic [1:0] ACC_LOAD = 2'b00;
    localparam logic [1:0] ACC_ADD  = 2'b01;
    localparam logic [1:0] ACC_SUB  = 2'b10;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       temp_hi_q, temp_hi_d;
    logic [31:0]       temp_lo_q, temp_lo_d;
    // Cleared for divide-by-zero so that completion leaves HI/LO untouched.
    logic              wr_q, wr_d;
`ifdef MDU_MADD_EN
    logic [1:0]        acc_q, acc_d;
    logic [63:0]       hilo_cur;
`endif

    logic signed [63:0] a_sx, b_sx, prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] a_s, b_s, quot_s, rem_s;
    logic        [31:0] div_b, quot_u, rem_u;
    logic               div_zero, div_ovf;
    logic               is_mult, is_div, is_acc;

    // Operand-only arithmetic: products and quotients computed every cycle and
    // captured only when an operation starts.
    always_comb begin
        a_sx     = {{32{A[31]}}, A};
        b_sx     = {{32{B[31]}}, B};
        prod_s   = a_sx * b_sx;
        prod_u   = {32'd0, A} * {32'd0, B};
        div_zero = (B == 32'd0);
        div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
        // The divisor is forced to 1 for B=0 (result discarded anyway) and for
        // the overflow case, where dividing by 1 gives exactly the required
        // LO=0x80000000 and HI=0.
        div_b    = div_zero ? 32'd1 : B;
        quot_u   = A / div_b;
        rem_u    = A % div_b;
        a_s      = A;
        b_s      = (div_zero || div_ovf) ? 32'sd1 : $signed(B);
        quot_s   = a_s / b_s;
        rem_s    = a_s % b_s;
    end

    // Decode of multi-cycle opcodes and the Start handshake to the stall logic.
    always_comb begin
        is_mult = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
        is_div  = (MDOp == OP_DIV)  || (MDOp == OP_DIVU);
`ifdef MDU_MADD_EN
        is_acc  = (MDOp == OP_MADD) || (MDOp == OP_MADDU) ||
                  (MDOp == OP_MSUB) || (MDOp == OP_MSUBU);
`else
        is_acc  = 1'b0;
`endif
        Start   = (state_q == IDLE) && (is_mult || is_div || is_acc);
    end

    // Next-state logic: launch in IDLE, count down in BUSY, and commit on the last count.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        temp_hi_d = temp_hi_q;
        temp_lo_d = temp_lo_q;
        wr_d      = wr_q;
`ifdef MDU_MADD_EN
        acc_d     = acc_q;
        hilo_cur  = {hi_q, lo_q};
`endif
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = BUSY;
                    wr_d    = 1'b1;
                    cnt_d   = CNT_W'(MULT_CYCLES);
`ifdef MDU_MADD_EN
                    acc_d   = ACC_LOAD;
`endif
                    case (MDOp)
                        OP_MULT:  {temp_hi_d, temp_lo_d} = prod_s;
                        OP_MULTU: {temp_hi_d, temp_lo_d} = prod_u;
                        OP_DIV: begin
                            temp_hi_d = rem_s;
                            temp_lo_d = quot_s;
                            wr_d      = !div_zero;
                            cnt_d     = CNT_W'(DIV_CYCLES);
                        end
                        OP_DIVU: begin
                            temp_hi_d = rem_u;
                            temp_lo_d = quot_u;
                            wr_d      = !div_zero;
                            cnt_d     = CNT_W'(DIV_CYCLES);
                        end
`ifdef MDU_MADD_EN
                        OP_MADD: begin
                            {temp_hi_d, temp_lo_d} = prod_s;
                            acc_d = ACC_ADD;
                        end
                        OP_MADDU: begin
                            {temp_hi_d, temp_lo_d} = prod_u;
                            acc_d = ACC_ADD;
                        end
                        OP_MSUB: begin
                            {temp_hi_d, temp_lo_d} = prod_s;
                            acc_d = ACC_SUB;
                        end
                        OP_MSUBU: begin
                            {temp_hi_d, temp_lo_d} = prod_u;
                            acc_d = ACC_SUB;
                        end
`endif
                        default: ;
                    endcase
                end else if (MDOp == OP_MTHI) begin
                    hi_d = A;
                end else if (MDOp == OP_MTLO) begin
                    lo_d = A;
                end
            end
            BUSY: begin
                // Any opcode arriving here is ignored; the held result is not disturbed.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (wr_q) begin
`ifdef MDU_MADD_EN
                        case (acc_q)
                            ACC_ADD: {hi_d, lo_d} = hilo_cur + {temp_hi_q, temp_lo_q};
                            ACC_SUB: {hi_d, lo_d} = hilo_cur - {temp_hi_q, temp_lo_q};
                            default: begin
                                hi_d = temp_hi_q;
                                lo_d = temp_lo_q;
                            end
                        endcase
`else
                        hi_d = temp_hi_q;
                        lo_d = temp_lo_q;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and data registers; reset immediately discards any in-flight result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            temp_hi_q <= '0;
            temp_lo_q <= '0;
            wr_q      <= 1'b0;
`ifdef MDU_MADD_EN
            acc_q     <= 2'b00;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            temp_hi_q <= temp_hi_d;
            temp_lo_q <= temp_lo_d;
            wr_q      <= wr_d;
`ifdef MDU_MADD_EN
            acc_q     <= acc_d;
`endif
        end
    end

    assign Busy = (state_q == BUSY);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Execute-stage multiply/divide unit with HI/LO registers for the P6 pipeline CPU. Handles mult, multu, div, divu, mthi and mtlo.
- Models multi-cycle latency with a busy counter. Drives Busy and Start, which the decode-stage stall logic uses to hold any HI/LO-class instruction (mult/div/mfhi/mflo/mthi/mtlo) in D.
- HI and LO go to the E-stage result mux for mfhi and mflo.

Parameters:
MULT_CYCLES, 5, Busy cycles for mult/multu (and madd-class when enabled); must be >=1
DIV_CYCLES, 10, Busy cycles for div/divu; must be >=1

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
MDOp  input  4  E-stage operation code, see Behaviour
A  input  32  rs operand, already forwarded
B  input  32  rt operand, already forwarded
Start  output  1  combinational; 1 when MDOp is a multi-cycle op and the unit is IDLE
Busy  output  1  registered; 1 while a multi-cycle op is in flight
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- MDOp encoding:
  - 0000 NOP
  - 0001 mult, 0010 multu
  - 0011 div, 0100 divu
  - 0101 mthi, 0110 mtlo
  - 0111 madd, 1000 maddu, 1001 msub, 1010 msubu (optional feature only)
  - Any other code is a NOP.
- Reset (async, immediate): HI=0, LO=0, Busy=0, counter=0, state IDLE. An in-flight result is discarded; reset mid-operation leaves HI/LO at 0.
- State machine, two states:
  - IDLE -> BUSY on a clock edge where Start=1. At that edge:
    - latch the computed result into internal temp_hi/temp_lo;
    - load the counter with MULT_CYCLES or DIV_CYCLES.
  - BUSY: the counter decrements each edge. On the edge where the counter is 1:
    - HI<=temp_hi, LO<=temp_lo;
    - counter becomes 0; return to IDLE.
- Timing, with Start sampled at edge k:
  - Busy=1 during cycles k+1 .. k+N;
  - new HI/LO become visible, and Busy=0, in cycle k+N+1.
- Start = IDLE & (MDOp in {0001..0100}, plus 0111..1010 when enabled). Purely combinational, with no dependence on A/B.
- mthi/mtlo: in IDLE, write HI<=A or LO<=A at the next edge; the other register is unchanged. While BUSY they are ignored and no write occurs.
- Any op arriving while BUSY is ignored: no restart, and temp registers unchanged. The stall logic prevents this; the unit must still be safe.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI=upper 32 bits, LO=lower 32 bits.
  - multu: unsigned 32x32 -> 64, same split.
  - div: signed. LO=quotient truncated toward zero; HI=remainder, with the sign of the dividend.
  - div overflow, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned quotient in LO, remainder in HI.
  - Divide by zero (B=0) for div/divu: the full DIV_CYCLES Busy window still runs, and HI/LO are left unchanged at completion.
- Busy and Start are never both 1.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - MDOp 0111-1010 are accepted as multi-cycle ops with MULT_CYCLES latency and assert Start.
  - At completion, {HI,LO} <= {HI,LO} ± product, modulo 2^64. Signed product for madd/msub, unsigned for maddu/msubu.
  - The HI/LO values used are those at completion; nothing else can write them while BUSY.
- Undefined: codes 0111-1010 are NOPs, Start=0, and no adder or accumulate path is synthesised.

Test Plan:
- Reset high mid-div (cycle 3 of 10), HI=LO=0x12345678 beforehand -> HI=LO=0 and Busy=0 immediately; after release the old result is never written.
- mult A=0xFFFFFFFF, B=0x00000002, Start at edge k -> Start=1 in cycle k, Busy=1 in cycles k+1..k+5; in cycle k+6, HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same operands with multu -> HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2 -> after 10 Busy cycles, LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu A=7, B=2 -> LO=3, HI=1.
- div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0. div with B=0 from HI=0xAA, LO=0xBB -> Busy for 10 cycles, then HI=0xAA, LO=0xBB.
- mthi A=0x55 in IDLE -> HI=0x55 next cycle, LO unchanged. mtlo while BUSY -> ignored. mult issued while BUSY -> Start=0 and the in-flight result is unaffected.
- With MDU_MADD_EN, HI=0, LO=0xFFFFFFFF, madd A=1, B=1 -> HI=1, LO=0 after 5 Busy cycles. Without the macro, same MDOp -> Start=0, Busy stays 0, HI/LO unchanged.
